// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment pattern decoder: segment patterns (abcdefg,
// bit 6 = a), their display codes, the FSM state type and the pattern-to-code map.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam logic [4:0] CODE_0     = 5'h00;
  localparam logic [4:0] CODE_1     = 5'h01;
  localparam logic [4:0] CODE_2     = 5'h02;
  localparam logic [4:0] CODE_3     = 5'h03;
  localparam logic [4:0] CODE_4     = 5'h04;
  localparam logic [4:0] CODE_5     = 5'h05;
  localparam logic [4:0] CODE_6     = 5'h06;
  localparam logic [4:0] CODE_7     = 5'h07;
  localparam logic [4:0] CODE_8     = 5'h08;
  localparam logic [4:0] CODE_9     = 5'h09;
  localparam logic [4:0] CODE_A     = 5'h0A;
  localparam logic [4:0] CODE_B     = 5'h0B;
  localparam logic [4:0] CODE_C     = 5'h0C;
  localparam logic [4:0] CODE_D     = 5'h0D;
  localparam logic [4:0] CODE_E     = 5'h0E;
  localparam logic [4:0] CODE_F     = 5'h0F;
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;
  localparam logic [4:0] CODE_ERR   = 5'h1F;

  typedef enum logic [1:0] {SETTLE, HOLD, PENDING} state_e;

  // Returns {err, code}; unknown patterns map to {1, CODE_ERR}.
  function automatic logic [5:0] seg7_to_code(input logic [6:0] pattern);
    case (pattern)
      SEG_0:     return {1'b0, CODE_0};
      SEG_1:     return {1'b0, CODE_1};
      SEG_2:     return {1'b0, CODE_2};
      SEG_3:     return {1'b0, CODE_3};
      SEG_4:     return {1'b0, CODE_4};
      SEG_5:     return {1'b0, CODE_5};
      SEG_6:     return {1'b0, CODE_6};
      SEG_7:     return {1'b0, CODE_7};
      SEG_8:     return {1'b0, CODE_8};
      SEG_9:     return {1'b0, CODE_9};
      SEG_A:     return {1'b0, CODE_A};
      SEG_B:     return {1'b0, CODE_B};
      SEG_C:     return {1'b0, CODE_C};
      SEG_D:     return {1'b0, CODE_D};
      SEG_E:     return {1'b0, CODE_E};
      SEG_F:     return {1'b0, CODE_F};
      SEG_BLANK: return {1'b0, CODE_BLANK};
      SEG_DASH:  return {1'b0, CODE_DASH};
      default:   return {1'b1, CODE_ERR};
    endcase
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Samples the segment bus and counts how long the sampled pattern has held.
// stable_o/reach_o look ahead to the counter value after the coming edge.
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  output logic [6:0] pat_o,
  output logic       change_o,
  output logic       stable_o,
  output logic       reach_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]       s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (seg_i != s_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= seg_i;
      cnt_q <= cnt_d;
    end
  end

  // Whenever stable_o is set, seg_i equals s_q, so s_q names the stable pattern.
  assign pat_o    = s_q;
  assign change_o = (seg_i != s_q);
  assign stable_o = (cnt_d == CNT_MAX);
  assign reach_o  = stable_o && (cnt_q != CNT_MAX);

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Decodes stable 7-segment patterns back to display codes, one event per new pattern.
// Define SEG_ACTIVE_LOW_EN for common-anode (active-low) segment inputs.
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [4:0] code_o,
  output logic       err_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overrun_o,
  input  logic       clr_overrun_i
);

  logic [6:0] seg_eff;
  logic [6:0] pat;
  logic       change;
  logic       stable;
  logic       reach;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_eff = ~seg_in;
`else
  assign seg_eff = seg_in;
`endif

  seg7_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_i    (seg_eff),
    .pat_o    (pat),
    .change_o (change),
    .stable_o (stable),
    .reach_o  (reach)
  );

  state_e     state_q, state_d;
  logic [6:0] last_rep_q, last_rep_d;
  logic [6:0] last_stab_q, last_stab_d;
  logic [6:0] pend_q, pend_d;
  logic [4:0] code_q, code_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;
  logic       load, accept, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE:  if (stable) state_d = (pat != last_rep_q) ? PENDING : HOLD;
      HOLD:    if (change) state_d = SETTLE;
      PENDING: if (ready_i) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase
  end

  // A drop is a fresh stable pattern seen while an event is still waiting; a
  // pattern that merely returns to the last stable value after a glitch is not one.
  always_comb begin
    load        = (state_q == SETTLE) && stable && (pat != last_rep_q);
    accept      = (state_q == PENDING) && ready_i;
    drop        = (state_q == PENDING) && reach && (pat != pend_q) && (pat != last_stab_q);
    pend_d      = load ? pat : pend_q;
    {err_d, code_d} = load ? seg7_to_code(pat) : {err_q, code_q};
    last_rep_d  = accept ? pend_q : last_rep_q;
    last_stab_d = reach ? pat : last_stab_q;
    ovr_d       = drop ? 1'b1 : (clr_overrun_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rep_q  <= SEG_BLANK;
      last_stab_q <= SEG_BLANK;
      pend_q      <= SEG_BLANK;
      code_q      <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      last_rep_q  <= last_rep_d;
      last_stab_q <= last_stab_d;
      pend_q      <= pend_d;
      code_q      <= code_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    valid_o   = (state_q == PENDING);
    code_o    = code_q;
    err_o     = err_q;
    overrun_o = ovr_q;
  end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Self-checking bench for seg7_pattern_decoder: directed scenarios plus random
// segment traffic compared every cycle against a history-based reference model.
module tb_seg7_pattern_decoder;

  localparam int N = 4;

  localparam logic [6:0] TBL [18] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111, 7'b0000000, 7'b0000001};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = '0;
  logic [4:0] code_o;
  logic       err_o, valid_o, overrun_o;
  logic       ready_i = 1'b0;
  logic       clr_overrun_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: logical patterns only.
  logic [6:0] hist[$];
  logic [6:0] m_pend = '0, m_last_rep = '0, m_last_stab = '0;
  logic       m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
  logic [4:0] m_code = '0;

  seg7_pattern_decoder #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .code_o        (code_o),
    .err_o         (err_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .overrun_o     (overrun_o),
    .clr_overrun_i (clr_overrun_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] lookup(input logic [6:0] p);
    for (int i = 0; i < 18; i++) if (TBL[i] == p) return {1'b0, 5'(i)};
    return {1'b1, 5'h1F};
  endfunction

  function automatic logic [6:0] logical(input logic [6:0] raw);
`ifdef SEG_ACTIVE_LOW_EN
    return ~raw;
`else
    return raw;
`endif
  endfunction

  task automatic drive(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
    seg_in = ~p;
`else
    seg_in = p;
`endif
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    drive(p);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a pattern is stable once the last N+1 samples agree
  // (the reset state counts as one blank sample).
  initial begin
    logic [6:0] s;
    logic stable, all2, reach, ovr_set;
    int sz;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        hist.push_back(7'b0);
        m_pend = '0; m_last_rep = '0; m_last_stab = '0;
        m_valid = 1'b0; m_err = 1'b0; m_code = '0; m_ovr = 1'b0;
      end else begin
        s = logical(seg_in);
        hist.push_back(s);
        if (hist.size() > N + 2) hist.delete(0);
        sz = hist.size();
        stable = (sz >= N + 1);
        if (stable) for (int i = 1; i <= N; i++) if (hist[sz-1-i] != s) stable = 1'b0;
        all2 = stable && (sz >= N + 2) && (hist[sz-2-N] == s);
        reach = stable && !all2;
        ovr_set = 1'b0;
        if (m_valid) begin
          if (reach && s != m_pend && s != m_last_stab) ovr_set = 1'b1;
          if (ready_i) begin
            m_last_rep = m_pend;
            m_valid = 1'b0;
          end
        end else if (stable && s != m_last_rep) begin
          m_pend = s;
          {m_err, m_code} = lookup(s);
          m_valid = 1'b1;
        end
        if (reach) m_last_stab = s;
        if (ovr_set) m_ovr = 1'b1;
        else if (clr_overrun_i) m_ovr = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid", valid_o, m_valid);
        check("code", code_o, m_code);
        check("err", err_o, m_err);
        check("overrun", overrun_o, m_ovr);
      end
    end
  end

  initial begin
    drive(7'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_code", code_o, 0);
    check("rst_err", err_o, 0);
    check("rst_overrun", overrun_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Blank after reset equals last reported: no event.
    ready_i = 1'b1;
    hold(7'b0000000, 20);
    #1 check("blank_no_event", valid_o, 0);

    // "1": valid exactly one cycle, appearing after edge E0+N.
    drive(7'b0110000);
    repeat (N) @(negedge clk);
    #1 check("one_early", valid_o, 0);
    @(negedge clk);
    #1 check("one_valid", valid_o, 1);
    check("one_code", code_o, 5'h01);
    check("one_err", err_o, 0);
    @(negedge clk);
    #1 check("one_once", valid_o, 0);
    hold(7'b0110000, 10);

    // Short-lived "6" is filtered; "8" reported.
    hold(7'b1011111, 3);
    hold(7'b1111111, 12);
    #1 check("eight_code", code_o, 5'h08);

    // Back-pressure: A pending, C and 0 dropped with overrun.
    ready_i = 1'b0;
    hold(7'b1110111, 8);
    hold(7'b1001110, 8);
    hold(7'b1111110, 8);
    #1 check("bp_code", code_o, 5'h0A);
    check("bp_valid", valid_o, 1);
    check("bp_overrun", overrun_o, 1);
    ready_i = 1'b1;
    hold(7'b1111110, 4);
    #1 check("bp_final_code", code_o, 5'h00);
    check("bp_final_valid", valid_o, 0);
    clr_overrun_i = 1'b1;
    @(negedge clk);
    clr_overrun_i = 1'b0;
    #1 check("clr_overrun", overrun_o, 0);

    // Error pattern.
    ready_i = 1'b0;
    hold(7'b1010101, 7);
    #1 check("err_flag", err_o, 1);
    check("err_code", code_o, 5'h1F);
    check("err_valid", valid_o, 1);
    ready_i = 1'b1;
    hold(7'b1010101, 3);

    // "3" pending, then "5" dropped, then async reset mid-event.
    ready_i = 1'b0;
    hold(7'b1111001, 7);
    #1 check("three_code", code_o, 5'h03);
    hold(7'b1011011, 7);
    #1 check("five_overrun", overrun_o, 1);
    #2 rst_n = 1'b0;
    #1 check("async_valid", valid_o, 0);
    check("async_code", code_o, 0);
    check("async_err", err_o, 0);
    check("async_overrun", overrun_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int seg = 0; seg < 400; seg++) begin
      logic [6:0] p;
      int len;
      p = ($urandom_range(0, 4) == 0) ? 7'($urandom) : TBL[$urandom_range(0, 17)];
      len = $urandom_range(1, N + 4);
      drive(p);
      for (int c = 0; c < len; c++) begin
        ready_i = ($urandom_range(0, 9) < 6);
        clr_overrun_i = ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
    end
    clr_overrun_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_decoder.md
Name: seg7_pattern_decoder

Overview:
- Receiver-side counterpart of the team's code-to-7-segment display decoder.
- Samples a 7-segment bus {a,b,c,d,e,f,g}, waits until the pattern has been stable for a configurable number of cycles, and maps it back to the 5-bit display code.
- Reports each new stable pattern once over a valid/ready handshake.
- Used to check and monitor display outputs in-system, and as a scoreboard front end for display benches.

Parameters:
- STABLE_CYCLES, 4, number of cycles a pattern must hold after capture before it is considered stable (legal range 1..255).
- CNT_W, 8, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment bus; bit 6 = a … bit 0 = g; active-high unless the optional feature is enabled.
- code_o  out  5  decoded code, equivalent to {c1..c5}; c1 is the MSB.
- err_o  out  1  stable pattern is not in the code table; code_o = 5'h1F.
- valid_o  out  1  code_o/err_o hold a new event.
- ready_i  in  1  consumer accepts the event.
- overrun_o  out  1  sticky: an intermediate stable pattern was dropped.
- clr_overrun_i  in  1  synchronous clear of overrun_o.

Behaviour:
- Reset (async assert, sync release):
  - outputs: code_o=0, err_o=0, valid_o=0, overrun_o=0.
  - internal: sample register=7'b0, counter=0, last_reported=7'b0000000 (blank), state=SETTLE.
- Code table, pattern abcdefg -> code:
  - 1111110->00, 0110000->01, 1101101->02, 1111001->03, 0110011->04, 1011011->05, 1011111->06, 1110000->07.
  - 1111111->08, 1111011->09, 1110111->0A, 0011111->0B, 1001110->0C, 0111101->0D, 1001111->0E, 1000111->0F.
  - 0000000->10 (blank), 0000001->11 (dash).
  - Any other pattern -> err_o=1, code_o=1F.
- Sampling:
  - s_q <= seg_in on every edge.
  - If seg_in != s_q, the counter clears to 0; otherwise it increments, saturating at STABLE_CYCLES.
- The pattern is stable when counter == STABLE_CYCLES. A pattern present before capture edge E0 through edge E0+STABLE_CYCLES gives valid_o high immediately after edge E0+STABLE_CYCLES.
- FSM states:
  - SETTLE:
    - stable && s_q != last_reported -> load code_o/err_o from the table, set valid_o=1, go to PENDING.
    - stable && s_q == last_reported -> go to HOLD.
  - HOLD: seg_in != s_q -> SETTLE (counter clears).
  - PENDING:
    - valid_o stays high; code_o/err_o are frozen.
    - On valid_o && ready_i: last_reported <= the reported pattern, valid_o <= 0, go to SETTLE.
    - A following cycle with a stable, different pattern then emits again, so there is no duplicate event and the final state is never lost.
- Overrun: in PENDING, if the counter reaches STABLE_CYCLES on a pattern different from both the pending pattern and the previous stable sample, set overrun_o. The pending event is kept; the intermediate pattern is dropped.
- clr_overrun_i clears overrun_o; a set on the same edge wins.
- ready_i while valid_o=0 is ignored. valid_o never drops without a handshake, except on reset.
- Reset asserted mid-PENDING discards the event; valid_o falls asynchronously.
- Error patterns are reported like codes and update last_reported.

Optional Feature:
- SEG_ACTIVE_LOW_EN defined: seg_in is inverted at the input, before the sample register (common-anode displays). The reset value of last_reported stays logical blank.
- Undefined: seg_in is used as-is (active-high).

Decomposition:
- Package seg7_pkg:
  - localparams for the 18 segment patterns and their codes.
  - CODE_ERR = 5'h1F.
  - state enum {SETTLE, HOLD, PENDING}.
  - pure function seg7_to_code(pattern) returning {err, code}.
- One sub-module, seg7_stable_filter:
  - contains the sample register, counter and stable flag.
  - parameters STABLE_CYCLES and CNT_W.
- The top level holds the FSM, last_reported, the handshake and overrun.

Test Plan:
- Reset, then hold seg_in=0000000 for 20 cycles -> valid_o stays 0 (blank equals last_reported).
- STABLE_CYCLES=4: seg_in=0110000, ready_i=1 -> valid_o high for exactly 1 cycle after edge E0+4, code_o=01, err_o=0; no repeat while the pattern is held.
- seg_in=1011111 for 3 cycles then 1111111 held -> the first pattern never reports; code_o=08 reported once.
- ready_i=0: apply 1110111 (stable), then 1001110 (stable), then 1111110 (stable) -> code_o stays 0A, overrun_o=1. Raise ready_i -> 0A accepted, then 00 reported; clr_overrun_i -> overrun_o=0.
- seg_in=1010101 stable -> err_o=1, code_o=1F, valid_o=1.
- With SEG_ACTIVE_LOW_EN: seg_in=0000110 -> code_o=03. Assert rst_n=0 mid-PENDING -> valid_o=0 asynchronously, all outputs at reset values.
